mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage of the 6-stage pipeline. Sits between the EX/MEM pipeline register and MEM_WB.
- Takes the ALU-computed address, store data and memory controls. Performs byte/half/word loads and stores over a ready-handshaked data-memory bus.
- Produces the extended load data that MEM_WB latches as Mem_Read_dat.
- Asserts a stall that freezes upstream stages until the memory transaction completes.

Parameters:
- TIMEOUT, 16, max cycles waiting for dmem_ready before abandoning the access with bus_error.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- MemReadIn  in  1  load request from EX/MEM.
- MemWriteIn  in  1  store request from EX/MEM.
- mem_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- ALU_result_out  in  32  byte address.
- write_data_in  in  32  store data, right-aligned.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = write, registered.
- dmem_addr  out  32  word address {addr[31:2],2'b00}, registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  32  store data replicated to the selected lanes, registered.
- dmem_ready  in  1  bus completion; dmem_rdata valid in the same cycle for reads.
- dmem_rdata  in  32  read word.
- Mem_Read_dat  out  32  extended load result to MEM_WB.
- mem_stall  out  1  combinational; 1 = hold PC and all upstream pipeline registers.
- misaligned_exc  out  1  one-cycle pulse on a misaligned access.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, Mem_Read_dat, misaligned_exc, bus_error and the counter all go to 0.
  - mem_stall = 0.
  - Reset asserted mid-access drops dmem_req immediately; the access is abandoned and no result is produced.
- Operation selection:
  - op = MemReadIn | MemWriteIn.
  - If both are set, the access is a store.
- Misalignment rule:
  - Halfword is misaligned when addr[0] = 1.
  - Word is misaligned when addr[1:0] ≠ 0.
- State IDLE:
  - op and aligned: mem_stall = 1. Register dmem_req = 1, dmem_we, dmem_addr, dmem_be and dmem_wdata; clear the counter; go to ACCESS.
  - op and misaligned: no request, mem_stall = 0. misaligned_exc = 1 next cycle for one cycle. Mem_Read_dat unchanged.
  - No op: mem_stall = 0.
- Byte enables:
  - byte: 0001 << addr[1:0].
  - half: 0011 << addr[1:0].
  - word: 1111.
- Store data lanes:
  - byte: the low byte replicated ×4.
  - half: the low half replicated ×2.
- State ACCESS:
  - mem_stall = 1 and dmem_req held at 1.
  - dmem_ready = 1 (completion):
    - For a read, shift dmem_rdata right by 8·addr[1:0], then extend per mem_size and mem_unsigned, and register it into Mem_Read_dat.
    - Drop dmem_req and go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ready:
    - Drop dmem_req.
    - Pulse bus_error for one cycle.
    - For a read, Mem_Read_dat = 0.
    - Go to DONE.
- State DONE:
  - mem_stall = 0, so the pipeline advances on this edge and MEM_WB captures Mem_Read_dat.
  - Unconditionally go to IDLE. A new op seen in the following cycle starts a new access.
- Latency:
  - Minimum load/store is 3 cycles from the op appearing: IDLE → ACCESS (with ready in the first ACCESS cycle) → DONE.
  - Stall length is 2 + wait cycles.
- Stores leave Mem_Read_dat unchanged.
- dmem_ready outside ACCESS is ignored.
- Upstream holds all inputs stable while mem_stall = 1.

Test Plan:
- Word load:
  - Stimulus: MemReadIn=1, size=10, addr=0x100; dmem_ready=1 on the first ACCESS cycle with rdata=0xDEADBEEF.
  - Required: dmem_addr=0x100, be=1111; Mem_Read_dat=0xDEADBEEF in DONE; mem_stall high for exactly 2 cycles.
- Signed byte load:
  - Stimulus: addr=0x103, size=00, unsigned=0, rdata=0x80000000.
  - Required: be=1000; Mem_Read_dat=0xFFFFFF80. Repeat with unsigned=1 → 0x00000080.
- Halfword store:
  - Stimulus: MemWriteIn=1, size=01, addr=0x206, data=0x1234ABCD.
  - Required: dmem_we=1, dmem_addr=0x204, be=1100, wdata=0xABCDABCD; Mem_Read_dat unchanged.
- Misaligned word load:
  - Stimulus: addr=0x102, size=10.
  - Required: no dmem_req, mem_stall stays 0, misaligned_exc high for one cycle.
- Timeout:
  - Stimulus: TIMEOUT=16, dmem_ready held at 0.
  - Required: dmem_req drops after 16 ACCESS cycles; bus_error pulses once; Mem_Read_dat=0; mem_stall releases in DONE.
- Reset mid-access:
  - Stimulus: assert reset during the 3rd ACCESS cycle.
  - Required: dmem_req=0 and mem_stall=0 immediately; after deassertion a word load from 0x0 completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage between EX/MEM and MEM_WB. Issues byte/half/word
//   loads and stores on a ready-handshaked data bus, extends load data into
//   Mem_Read_dat and stalls upstream until the access finishes.
//
//   State table
//     IDLE   | no access in flight; launches a bus request on an aligned op
//     ACCESS | request held on the bus, waiting for dmem_ready or timeout
//     DONE   | result valid, stall released so MEM_WB captures Mem_Read_dat
//
//   Ports
//     clock, reset                    clock and async active-high reset
//     MemReadIn, MemWriteIn           load / store request (both = store)
//     mem_size, mem_unsigned          access width and load extension
//     ALU_result_out, write_data_in   byte address and right-aligned store data
//     dmem_req/we/addr/be/wdata       registered bus request
//     dmem_ready, dmem_rdata          bus completion and read word
//     Mem_Read_dat                    extended load result
//     mem_stall                       combinational upstream hold
//     misaligned_exc, bus_error       one-cycle exception pulses
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] ALU_result_out,
  input  logic [31:0] write_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Mem_Read_dat,
  output logic        mem_stall,
  output logic        misaligned_exc,
  output logic        bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdat;
  logic               r_mis;
  logic               r_berr;

  logic               w_op;
  logic               w_misaligned;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_shifted;
  logic [31:0]        w_load;

  assign w_op = MemReadIn | MemWriteIn;

  always_comb begin
    w_misaligned = 1'b0;
    case (mem_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = ALU_result_out[0];
      default: w_misaligned = |ALU_result_out[1:0];
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data_in;
    case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << ALU_result_out[1:0];
        w_wdata = {4{write_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << ALU_result_out[1:0];
        w_wdata = {2{write_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = write_data_in;
      end
    endcase
  end

  // Inputs are held stable during the stall, so the address and size seen
  // in ACCESS still describe the access that was launched.
  assign w_shifted = dmem_rdata >> {ALU_result_out[1:0], 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (mem_size)
      2'b00:   w_load = mem_unsigned ? {24'h0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = mem_unsigned ? {16'h0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdat  <= '0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_op && !w_misaligned) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteIn;
            r_addr  <= {ALU_result_out[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_state <= S_ACCESS;
          end else if (w_op) begin
            r_mis <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (dmem_ready) begin
            if (!r_we) r_rdat <= w_load;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            if (!r_we) r_rdat <= '0;
            r_req   <= 1'b0;
            r_berr  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset forces the stall low even if an op is still presented upstream.
  assign mem_stall = !reset &&
                     ((r_state == S_ACCESS) ||
                      ((r_state == S_IDLE) && w_op && !w_misaligned));

  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_be        = r_be;
  assign dmem_wdata     = r_wdata;
  assign Mem_Read_dat   = r_rdat;
  assign misaligned_exc = r_mis;
  assign bus_error      = r_berr;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clock;
  logic        reset;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] ALU_result_out;
  logic [31:0] write_data_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] Mem_Read_dat;
  logic        mem_stall;
  logic        misaligned_exc;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .MemReadIn      (MemReadIn),
    .MemWriteIn     (MemWriteIn),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .ALU_result_out (ALU_result_out),
    .write_data_in  (write_data_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .Mem_Read_dat   (Mem_Read_dat),
    .mem_stall      (mem_stall),
    .misaligned_exc (misaligned_exc),
    .bus_error      (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_cyc;   // >= 16 means ready never comes
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_op();
    MemReadIn  = 1'b0;
    MemWriteIn = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int stall_cnt;
    int acc_cyc;
    int exp_stall;
    logic [31:0] rdat_before;
    @(negedge clock);
    rdat_before    = Mem_Read_dat;
    MemReadIn      = v.rd;
    MemWriteIn     = v.wr;
    mem_size       = v.size;
    mem_unsigned   = v.uns;
    ALU_result_out = v.addr;
    write_data_in  = v.wdata;
    dmem_rdata     = v.rdata;
    dmem_ready     = 1'b0;
    #1;
    if (v.exp_mis) begin
      chk({v.name, ".stall_idle"}, 32'(mem_stall), 32'd0);
      @(negedge clock);
      chk({v.name, ".exc"}, 32'(misaligned_exc), 32'd1);
      chk({v.name, ".no_req"}, 32'(dmem_req), 32'd0);
      chk({v.name, ".stall"}, 32'(mem_stall), 32'd0);
      clear_op();
      @(negedge clock);
      chk({v.name, ".exc_pulse"}, 32'(misaligned_exc), 32'd0);
      chk({v.name, ".rdat_kept"}, Mem_Read_dat, rdat_before);
      return;
    end
    chk({v.name, ".stall_idle"}, 32'(mem_stall), 32'd1);
    stall_cnt = 1;
    @(negedge clock);
    chk({v.name, ".req"}, 32'(dmem_req), 32'd1);
    chk({v.name, ".we"}, 32'(dmem_we), 32'(v.exp_we));
    chk({v.name, ".addr"}, dmem_addr, v.exp_addr);
    chk({v.name, ".be"}, 32'(dmem_be), 32'(v.exp_be));
    if (v.exp_we) chk({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
    acc_cyc = 0;
    while (mem_stall && acc_cyc < 40) begin
      stall_cnt++;
      dmem_ready = (acc_cyc == v.wait_cyc);
      acc_cyc++;
      @(negedge clock);
      if (mem_stall && !dmem_req) begin
        chk({v.name, ".req_held"}, 32'(dmem_req), 32'd1);
      end
    end
    dmem_ready = 1'b0;
    if (acc_cyc >= 40) begin
      chk({v.name, ".budget"}, 32'(acc_cyc), 32'd0);
      clear_op();
      return;
    end
    exp_stall = (v.wait_cyc >= 16) ? 17 : 2 + v.wait_cyc;
    chk({v.name, ".stall_len"}, 32'(stall_cnt), 32'(exp_stall));
    chk({v.name, ".req_drop"}, 32'(dmem_req), 32'd0);
    chk({v.name, ".rdat"}, Mem_Read_dat, v.exp_rdat);
    chk({v.name, ".berr"}, 32'(bus_error), (v.wait_cyc >= 16) ? 32'd1 : 32'd0);
    clear_op();
    @(negedge clock);
    chk({v.name, ".berr_pulse"}, 32'(bus_error), 32'd0);
    chk({v.name, ".idle_stall"}, 32'(mem_stall), 32'd0);
  endtask

  initial begin
    //          name        rd   wr   size  uns  addr          wdata         rdata         wait mis  exp_addr      be       we   exp_wdata     exp_rdat
    vecs[0]  = '{"ld_word",  1'b1,1'b0,2'b10,1'b0,32'h0000_0100,32'h0,        32'hDEAD_BEEF,0,  1'b0,32'h0000_0100,4'b1111,1'b0,32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{"ld_sb",    1'b1,1'b0,2'b00,1'b0,32'h0000_0103,32'h0,        32'h8000_0000,0,  1'b0,32'h0000_0100,4'b1000,1'b0,32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{"ld_ub",    1'b1,1'b0,2'b00,1'b1,32'h0000_0103,32'h0,        32'h8000_0000,0,  1'b0,32'h0000_0100,4'b1000,1'b0,32'h0,        32'h0000_0080};
    vecs[3]  = '{"st_half",  1'b0,1'b1,2'b01,1'b0,32'h0000_0206,32'h1234_ABCD,32'h0,        2,  1'b0,32'h0000_0204,4'b1100,1'b1,32'hABCD_ABCD,32'h0000_0080};
    vecs[4]  = '{"ld_sh",    1'b1,1'b0,2'b01,1'b0,32'h0000_0102,32'h0,        32'h8001_1234,1,  1'b0,32'h0000_0100,4'b1100,1'b0,32'h0,        32'hFFFF_8001};
    vecs[5]  = '{"mis_word", 1'b1,1'b0,2'b10,1'b0,32'h0000_0102,32'h0,        32'h0,        0,  1'b1,32'h0,        4'b0000,1'b0,32'h0,        32'hFFFF_8001};
    vecs[6]  = '{"st_byte",  1'b0,1'b1,2'b00,1'b0,32'h0000_0101,32'h0000_00A5,32'h0,        0,  1'b0,32'h0000_0100,4'b0010,1'b1,32'hA5A5_A5A5,32'hFFFF_8001};
    vecs[7]  = '{"mis_half", 1'b0,1'b1,2'b01,1'b0,32'h0000_0205,32'h0,        32'h0,        0,  1'b1,32'h0,        4'b0000,1'b0,32'h0,        32'hFFFF_8001};
    vecs[8]  = '{"ld_uh",    1'b1,1'b0,2'b01,1'b1,32'h0000_0100,32'h0,        32'h1234_F00D,0,  1'b0,32'h0000_0100,4'b0011,1'b0,32'h0,        32'h0000_F00D};
    vecs[9]  = '{"ld_sz11",  1'b1,1'b0,2'b11,1'b0,32'h0000_010C,32'h0,        32'h55AA_55AA,0,  1'b0,32'h0000_010C,4'b1111,1'b0,32'h0,        32'h55AA_55AA};
    vecs[10] = '{"timeout",  1'b1,1'b0,2'b10,1'b0,32'h0000_0300,32'h0,        32'h1111_1111,99, 1'b0,32'h0000_0300,4'b1111,1'b0,32'h0,        32'h0000_0000};
    vecs[11] = '{"rw_both",  1'b1,1'b1,2'b10,1'b0,32'h0000_0040,32'hCAFE_F00D,32'h0,        0,  1'b0,32'h0000_0040,4'b1111,1'b1,32'hCAFE_F00D,32'h0000_0000};
    vecs[12] = '{"ld_sb7f",  1'b1,1'b0,2'b00,1'b0,32'h0000_0101,32'h0,        32'h0000_7F00,3,  1'b0,32'h0000_0100,4'b0010,1'b0,32'h0,        32'h0000_007F};
    vecs[13] = '{"ld_after", 1'b1,1'b0,2'b10,1'b0,32'h0000_0000,32'h0,        32'h1357_9BDF,0,  1'b0,32'h0000_0000,4'b1111,1'b0,32'h0,        32'h1357_9BDF};

    reset          = 1'b1;
    MemReadIn      = 1'b0;
    MemWriteIn     = 1'b0;
    mem_size       = 2'b00;
    mem_unsigned   = 1'b0;
    ALU_result_out = '0;
    write_data_in  = '0;
    dmem_ready     = 1'b0;
    dmem_rdata     = '0;
    repeat (2) @(negedge clock);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.rdat", Mem_Read_dat, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Ready with no op pending must not start anything.
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    @(negedge clock);
    chk("idle_ready.req", 32'(dmem_req), 32'd0);
    chk("idle_ready.rdat", Mem_Read_dat, 32'd0);
    dmem_ready = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset during the third ACCESS cycle.
    @(negedge clock);
    MemReadIn      = 1'b1;
    mem_size       = 2'b10;
    ALU_result_out = 32'h0000_0080;
    dmem_ready     = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrst.req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst.req", 32'(dmem_req), 32'd0);
    chk("midrst.stall", 32'(mem_stall), 32'd0);
    chk("midrst.rdat", Mem_Read_dat, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    clear_op();
    @(negedge clock);
    chk("midrst.idle", 32'(dmem_req), 32'd0);
    run_vec(vecs[13]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
